// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output-side blocks: default sizes, reader
// states and the index reversal used by both RTL and benches.
package fft_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int N_DEF     = 16;
  localparam int LOG2N     = $clog2(N_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // rev_mode != 0 reverses base-4 digits (log2n must be even), else reverses bits.
  function automatic int rev_index(input int idx, input int log2n, input int rev_mode);
    int r;
    int v;
    r = 0;
    v = idx;
    for (int b = 0; b < 32; b++) begin
      if (rev_mode != 0) begin
        if (2 * b < log2n) begin
          r = (r << 2) | (v & 3);
          v = v >> 2;
        end
      end else if (b < log2n) begin
        r = (r << 1) | (v & 1);
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// Streaming bus between the FFT core, the reorder buffer and its consumer.
interface fft_output_reorder_if #(
  parameter int WIDTH = 32,
  parameter int N     = 16
);
  localparam int LW = $clog2(N);

  logic                    input_en;
  logic signed [WIDTH-1:0] input_real;
  logic signed [WIDTH-1:0] input_imag;
  logic                    output_en;
  logic signed [WIDTH-1:0] output_real;
  logic signed [WIDTH-1:0] output_imag;
  logic [LW-1:0]           output_index;
  logic                    output_last;

  modport slave (
    input  input_en, input_real, input_imag,
    output output_en, output_real, output_imag, output_index, output_last
  );

  modport master (
    output input_en, input_real, input_imag,
    input  output_en, output_real, output_imag, output_index, output_last
  );
endinterface

// File: rtl/fft_reorder_bank.sv
// Ping-pong storage: 2^AW words, synchronous write, asynchronous read.
module fft_reorder_bank #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fft_output_reorder.sv
// Reorders digit/bit-reversed FFT bins into natural order through a two-bank
// ping-pong buffer; adds bin index and end-of-frame sideband.
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int N        = N_DEF,
  parameter int REV_MODE = 1
) (
  input  logic clock,
  input  logic reset,
  fft_output_reorder_if.slave bus
);
  localparam int LW = $clog2(N);

  logic [LW-1:0]           wcnt_q, wcnt_d, rcnt_q, rcnt_d, idx_q, idx_d, wrev;
  logic                    wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0]              full_q, full_d;
  rd_state_e               state_q, state_d;
  logic                    en_q, en_d, last_q, last_d;
  logic signed [WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [2*WIDTH-1:0]      rdata;

  assign wrev = LW'(rev_index(int'(wcnt_q), LW, REV_MODE));

  fft_reorder_bank #(.DW(2 * WIDTH), .AW(LW + 1)) u_bank (
    .clock   (clock),
    .we_i    (bus.input_en),
    .waddr_i ({wbank_q, wrev}),
    .wdata_i ({bus.input_real, bus.input_imag}),
    .raddr_i ({rbank_q, rcnt_q}),
    .rdata_o (rdata)
  );

  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    state_d = state_q;
    idx_d   = idx_q;
    re_d    = re_q;
    im_d    = im_q;
    en_d    = 1'b0;
    last_d  = 1'b0;

    if (bus.input_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LW'(N - 1)) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    case (state_q)
      IDLE: if (full_q[rbank_q]) state_d = READ;
      READ: begin
        re_d   = $signed(rdata[2*WIDTH-1:WIDTH]);
        im_d   = $signed(rdata[WIDTH-1:0]);
        idx_d  = rcnt_q;
        en_d   = 1'b1;
        last_d = (rcnt_q == LW'(N - 1));
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LW'(N - 1)) begin
          full_d[rbank_q] = 1'b0;
          rbank_d         = ~rbank_q;
          // full_d already includes a fill landing on this same edge.
          if (!full_d[~rbank_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
      full_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      re_q    <= re_d;
      im_q    <= im_d;
      en_q    <= en_d;
      last_q  <= last_d;
    end
  end

  assign bus.output_en    = en_q;
  assign bus.output_last  = last_q;
  assign bus.output_real  = re_q;
  assign bus.output_imag  = im_q;
  assign bus.output_index = idx_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder: base-4 and bit-reversed instances fed
// with identical streams.
module tb_fft_output_reorder;
  import fft_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fft_output_reorder_if #(.WIDTH(32), .N(16)) bus4 ();
  fft_output_reorder_if #(.WIDTH(32), .N(16)) bus2 ();

  assign bus2.input_en   = bus4.input_en;
  assign bus2.input_real = bus4.input_real;
  assign bus2.input_imag = bus4.input_imag;

  fft_output_reorder #(.WIDTH(32), .N(16), .REV_MODE(1)) u_dut4 (
    .clock (clock), .reset (reset), .bus (bus4.slave));
  fft_output_reorder #(.WIDTH(32), .N(16), .REV_MODE(0)) u_dut2 (
    .clock (clock), .reset (reset), .bus (bus2.slave));

  int n_cmp = 0;
  int n_bad = 0;

  int exp4 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int exp2 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  // A fill must never write the bank still being read (except alongside its final read).
  always @(posedge clock) begin
    if (reset && bus4.input_en && u_dut4.state_q == READ && u_dut4.rcnt_q != 4'd15 &&
        u_dut4.wbank_q == u_dut4.rbank_q) begin
      n_bad++;
      $display("FAIL bank_collision: wbank=%0d rbank=%0d required different",
               u_dut4.wbank_q, u_dut4.rbank_q);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int base, input int cnt, input bit gapped);
    for (int p = 0; p < cnt; p++) begin
      @(negedge clock);
      bus4.input_en   = 1'b1;
      bus4.input_real = base + p;
      bus4.input_imag = -(base + p);
      if (gapped && p < cnt - 1) begin
        @(negedge clock);
        bus4.input_en = 1'b0;
      end
    end
    @(negedge clock);
    bus4.input_en   = 1'b0;
    bus4.input_real = 0;
    bus4.input_imag = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus4.input_en = 1'b0; bus4.input_real = 0; bus4.input_imag = 0;
    repeat (3) @(negedge clock);
    n_cmp++; if (bus4.output_en !== 1'b0) begin n_bad++;
      $display("FAIL rst_en: got %b want 0", bus4.output_en); end
    n_cmp++; if (bus4.output_last !== 1'b0) begin n_bad++;
      $display("FAIL rst_last: got %b want 0", bus4.output_last); end
    n_cmp++; if (bus4.output_real !== 32'sd0) begin n_bad++;
      $display("FAIL rst_real: got %0d want 0", bus4.output_real); end
    n_cmp++; if (bus4.output_imag !== 32'sd0) begin n_bad++;
      $display("FAIL rst_imag: got %0d want 0", bus4.output_imag); end
    n_cmp++; if (bus4.output_index !== 4'd0) begin n_bad++;
      $display("FAIL rst_index: got %0d want 0", bus4.output_index); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single_frame(input int base, input bit gapped, input string tag);
    send(base, 16, gapped);
    n_cmp++; if (bus4.output_en !== 1'b0) begin n_bad++;
      $display("FAIL %s_lat_e1: output_en got %b want 0", tag, bus4.output_en); end
    @(negedge clock);
    n_cmp++; if (bus4.output_en !== 1'b0) begin n_bad++;
      $display("FAIL %s_lat_e2: output_en got %b want 0", tag, bus4.output_en); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      n_cmp++; if (bus4.output_en !== 1'b1 || bus4.output_real !== base + exp4[k] ||
                   bus4.output_imag !== -(base + exp4[k])) begin n_bad++;
        $display("FAIL %s_bin%0d: en=%b re=%0d im=%0d want en=1 re=%0d im=%0d", tag, k,
                 bus4.output_en, bus4.output_real, bus4.output_imag, base + exp4[k],
                 -(base + exp4[k])); end
      n_cmp++; if (bus4.output_index !== 4'(k) || bus4.output_last !== (k == 15)) begin
        n_bad++;
        $display("FAIL %s_side%0d: index=%0d last=%b want index=%0d last=%b", tag, k,
                 bus4.output_index, bus4.output_last, k, (k == 15)); end
    end
    @(negedge clock);
    n_cmp++; if (bus4.output_en !== 1'b0) begin n_bad++;
      $display("FAIL %s_end: output_en got %b want 0", tag, bus4.output_en); end
  endtask

  task automatic test_bitrev();
    send(0, 16, 1'b0);
    @(negedge clock);
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      n_cmp++; if (bus2.output_en !== 1'b1 || bus2.output_real !== exp2[k] ||
                   bus2.output_imag !== -exp2[k] || bus2.output_index !== 4'(k)) begin
        n_bad++;
        $display("FAIL bitrev_bin%0d: en=%b re=%0d im=%0d idx=%0d want en=1 re=%0d im=%0d idx=%0d",
                 k, bus2.output_en, bus2.output_real, bus2.output_imag, bus2.output_index,
                 exp2[k], -exp2[k], k); end
    end
    @(negedge clock);
    n_cmp++; if (bus2.output_en !== 1'b0) begin n_bad++;
      $display("FAIL bitrev_end: output_en got %b want 0", bus2.output_en); end
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int p = 0; p < 32; p++) begin
          @(negedge clock);
          bus4.input_en   = 1'b1;
          bus4.input_real = (p < 16) ? p : p - 16 + 100;
          bus4.input_imag = (p < 16) ? -p : -(p - 16 + 100);
        end
        @(negedge clock);
        bus4.input_en = 1'b0;
      end
      begin
        int t;
        int v;
        t = 0;
        while (bus4.output_en !== 1'b1 && t < 60) begin
          @(negedge clock);
          t++;
        end
        n_cmp++; if (t >= 60) begin n_bad++;
          $display("FAIL b2b_start: output_en never rose, want 1 within 60 cycles"); end
        for (int k = 0; k < 32; k++) begin
          v = (k < 16) ? exp4[k] : 100 + exp4[k - 16];
          n_cmp++; if (bus4.output_en !== 1'b1 || bus4.output_real !== v ||
                       bus4.output_imag !== -v || bus4.output_last !== (k % 16 == 15)) begin
            n_bad++;
            $display("FAIL b2b_out%0d: en=%b re=%0d im=%0d last=%b want en=1 re=%0d im=%0d last=%b",
                     k, bus4.output_en, bus4.output_real, bus4.output_imag, bus4.output_last,
                     v, -v, (k % 16 == 15)); end
          @(negedge clock);
        end
        n_cmp++; if (bus4.output_en !== 1'b0) begin n_bad++;
          $display("FAIL b2b_end: output_en got %b want 0", bus4.output_en); end
      end
    join
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    for (int p = 0; p < 23; p++) begin
      @(negedge clock);
      bus4.input_en   = 1'b1;
      bus4.input_real = (p < 16) ? 200 + p : 300 + p - 16;
      bus4.input_imag = (p < 16) ? -(200 + p) : -(300 + p - 16);
    end
    @(negedge clock);
    bus4.input_en = 1'b0;
    n_cmp++; if (bus4.output_en !== 1'b1 || bus4.output_real !== 205) begin n_bad++;
      $display("FAIL mid_pre: en=%b re=%0d want en=1 re=205", bus4.output_en,
               bus4.output_real); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus4.output_en !== 1'b0 || bus4.output_last !== 1'b0) begin n_bad++;
      $display("FAIL mid_async_ctl: en=%b last=%b want 0 0", bus4.output_en,
               bus4.output_last); end
    n_cmp++; if (bus4.output_real !== 32'sd0 || bus4.output_imag !== 32'sd0 ||
                 bus4.output_index !== 4'd0) begin n_bad++;
      $display("FAIL mid_async_data: re=%0d im=%0d idx=%0d want 0 0 0", bus4.output_real,
               bus4.output_imag, bus4.output_index); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    test_single_frame(400, 1'b0, "after_rst");
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus4.output_en === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++;
      $display("FAIL stale_out: %0d extra output cycles, want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single_frame(0, 1'b0, "single");
    test_bitrev();
    test_single_frame(50, 1'b1, "gapped");
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Output reorder buffer directly downstream of fft_top (radix-4 SDF, 16-point, 32-bit).
- fft_top emits each frame's bins in digit-reversed order; this block writes them into a ping-pong buffer at reversed addresses and streams them out in natural order (X[0]..X[N-1]).
- Carries the same valid-only streaming interface as fft_top; adds frame-boundary and bin-index sideband outputs for the consumer.

Parameters:
- WIDTH, 32, bit width of each real/imag component (signed).
- N, 16, frame length in bins; power of 2; power of 4 when REV_MODE=1.
- REV_MODE, 1, 1 = base-4 digit reversal (radix-4 SDF); 0 = binary bit reversal (radix-2 variants).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_en  in  1  input sample valid; connects to fft_top output_en.
- input_real  in  WIDTH  signed real part; connects to fft_top output_real.
- input_imag  in  WIDTH  signed imag part; connects to fft_top output_imag.
- output_en  out  1  output sample valid.
- output_real  out  WIDTH  signed real part, natural bin order.
- output_imag  out  WIDTH  signed imag part, natural bin order.
- output_index  out  log2(N)  bin index k of the current output.
- output_last  out  1  high with bin N-1 of each frame.

Behaviour:
- Reset (async, reset=0): output_en=0, output_last=0, output_real=0, output_imag=0, output_index=0. Also clears wcnt, wbank, rbank, rcnt and full[1:0]; reader FSM goes to IDLE. RAM contents are not cleared.
- Storage: two banks, each N x 2*WIDTH. RAM write is synchronous; RAM read is asynchronous.
- Write side:
  - On each clock with input_en=1, write {real, imag} to bank wbank at address rev(wcnt), then increment wcnt.
  - Gaps (input_en=0) hold wcnt.
  - When wcnt wraps from N-1 to 0: set full[wbank] and toggle wbank.
- rev():
  - REV_MODE=1: reverse the base-4 digits of the index (N=16: d1d0 -> d0d1).
  - REV_MODE=0: reverse all log2(N) bits.
- Reader FSM, states IDLE and READ:
  - IDLE -> READ when full[rbank]=1. The first read address is presented in the cycle after the bank's last write edge.
  - READ: each cycle, register mem[rbank][rcnt] onto output_real/output_imag, set output_index=rcnt, set output_en=1, and set output_last=(rcnt==N-1). Then increment rcnt.
  - After reading rcnt=N-1: clear full[rbank] and toggle rbank.
  - If the newly selected bank is already full (or becomes full on that same edge), stay in READ with no idle cycle, so two frames stream back to back. Otherwise go to IDLE.
- Latency: last input sample of a frame captured at edge E -> output_en high from edge E+2 for exactly N consecutive cycles. No backpressure.
- Simultaneous events:
  - A write filling bank A on the same edge the reader frees bank B is legal; both flag updates take effect.
  - A write never targets the bank being read: the fill time (>= N cycles) is at least the read time (N cycles). The bench asserts this.
- Reset mid-frame: a partially written frame is discarded and a frame mid-read is truncated. The next input sample after reset release becomes bin position 0 of a new frame.
- Data passes unmodified: no scaling, no rounding.

Decomposition:
- Shared package fft_pkg holds:
  - Default WIDTH/N.
  - Localparam LOG2N.
  - Function rev_index(idx, log2n, rev_mode), reused by testbenches and any input-side reorder.
- Sub-module fft_reorder_bank: parameterised dual-port RAM (N entries x 2*WIDTH) with sync write and async read. Instantiated once with a bank-select address MSB, giving 2N entries.
- The top level holds counters, full flags and the FSM.

Test Plan:
- Single frame, N=16, REV_MODE=1: input position p gives real=p, imag=-p, one per cycle. Required output real sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15 with imag the negation of each, output_index 0..15, output_last only on the 16th. First output_en exactly 2 cycles after the last input edge.
- REV_MODE=0, same stimulus: required output real 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
- Two frames back to back (32 consecutive input_en cycles, frame 2 real=p+100): output_en high for 32 consecutive cycles with no gap. Frame 2 outputs 100,104,108,112,...,115.
- Gapped input (input_en toggling 1,0): output starts 2 cycles after the 16th valid sample and still emits 16 contiguous outputs in correct order.
- Reset asserted after 7 samples: all outputs 0 immediately, with no clock edge needed. After release, a full 16-sample frame reorders correctly and the discarded 7 samples never appear.
- Integration: fft_top feeding this block with the cosine test input. Bins appear in natural order, with the energy in bins 1 and 15 (real ≈ ±N*32768/2 scaled per fft_top) and the other bins ≈ 0.
